// File: rtl/mem_arbiter.sv
// Round-robin, non-preemptive arbiter between the I-cache and D-cache
// for one shared memory port, with a bounded count of outstanding reads.
module mem_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic        d_wr,
    input  logic [15:0] d_wdata,
    input  logic        mem_data_valid,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        I_mem_enable,
    output logic        D_mem_enable,
    output logic        i_data_valid,
    output logic        d_data_valid,
    output logic        i_mem_stall,
    output logic        d_mem_stall,
    output logic        err_spurious
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        DRAIN
    } state_t;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    state_t     state;
    state_t     state_next;
    logic [2:0] outstanding;
    logic [2:0] outstanding_next;
    logic       owner;
    logic       rr;
    logic       can_issue;
    logic       rd_issue;
    logic       rd_return;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            outstanding  <= 3'd0;
            owner        <= SIDE_I;
            rr           <= SIDE_D;
            err_spurious <= 1'b0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            if (state == IDLE && state_next == GRANT_I)
                owner <= SIDE_I;
            if (state == IDLE && state_next == GRANT_D)
                owner <= SIDE_D;
            // rr remembers the side that most recently released the port
            if (state == GRANT_I && state_next != GRANT_I)
                rr <= SIDE_I;
            if (state == GRANT_D && state_next != GRANT_D)
                rr <= SIDE_D;
            if (mem_data_valid && outstanding == 3'd0)
                err_spurious <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (i_req && d_req)
                    state_next = (rr == SIDE_D) ? GRANT_I : GRANT_D;
                else if (i_req)
                    state_next = GRANT_I;
                else if (d_req)
                    state_next = GRANT_D;
            end
            GRANT_I: begin
                if (!i_req)
                    state_next = (outstanding_next == 3'd0) ? IDLE : DRAIN;
            end
            GRANT_D: begin
                if (!d_req)
                    state_next = (outstanding_next == 3'd0) ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (outstanding_next == 3'd0)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        I_mem_enable = (state == GRANT_I);
        D_mem_enable = (state == GRANT_D);
        can_issue    = (outstanding < 3'(MAX_OUTSTANDING));
        mem_enable   = ((I_mem_enable && i_req) || (D_mem_enable && d_req))
                       && can_issue;
        mem_wr       = mem_enable && D_mem_enable && d_wr;
        mem_addr     = 16'd0;
        if (mem_enable)
            mem_addr = D_mem_enable ? d_addr : i_addr;
        mem_wdata    = mem_wr ? d_wdata : 16'd0;
        rd_issue     = mem_enable && !mem_wr;
        // returns with nothing in flight are dropped, never routed
        rd_return    = mem_data_valid && (outstanding != 3'd0);
        i_data_valid = rd_return && (owner == SIDE_I);
        d_data_valid = rd_return && (owner == SIDE_D);
        i_mem_stall  = i_req && !(I_mem_enable && can_issue);
        d_mem_stall  = d_req && !(D_mem_enable && can_issue);
        unique case ({rd_issue, rd_return})
            2'b10:   outstanding_next = outstanding + 3'd1;
            2'b01:   outstanding_next = outstanding - 3'd1;
            default: outstanding_next = outstanding;
        endcase
    end

endmodule
